muldiv_unit: RTL

- Iterative multiply/divide unit beside the execute stage. Consumes the EX-stage register operands and owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces a stall signal that freezes the fetch, decode and execute stages while an operation is in flight.
- Produces HI/LO values that the execute stage muxes onto its ALU output for MFHI/MFLO.

---
 rtl/muldiv_unit_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared op encodings, FSM state encodings and latency default
//               for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int MD_CYCLES_DFLT = 33;

    // Codes 0..3 are the iterative mul/div ops.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative shift-add multiplier / restoring divider owning the
//               HI/LO registers; stalls the front of the pipeline while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = MD_CYCLES_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EX_md_start,
    input  logic [2:0]      EX_md_op,
    input  logic [XLEN-1:0] EX_rd1,
    input  logic [XLEN-1:0] EX_rd2,
    output logic            MD_stall,
    output logic            MD_done,
    output logic [XLEN-1:0] MD_hi,
    output logic [XLEN-1:0] MD_lo
);

    localparam int                   c_cnt_w = $clog2(MD_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_iters = c_cnt_w'(MD_CYCLES - 1);

    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_mq;
    logic [XLEN-1:0]    r_opb;
    logic [XLEN-1:0]    r_rs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dvz;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic               r_done;

    logic               w_signed;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_is_div;
    logic [XLEN:0]      w_add;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_sub;
    logic               w_qbit;
    logic [XLEN-1:0]    w_acc_nxt;
    logic [XLEN-1:0]    w_mq_nxt;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_res_hi;
    logic [XLEN-1:0]    w_res_lo;

    assign w_signed = (EX_md_op == MD_MULT) || (EX_md_op == MD_DIV);
    assign w_mag_a  = (w_signed && EX_rd1[XLEN-1]) ? -EX_rd1 : EX_rd1;
    assign w_mag_b  = (w_signed && EX_rd2[XLEN-1]) ? -EX_rd2 : EX_rd2;
    assign w_is_div = r_op[1];

    // Multiply: {acc, mq} shifts right, adding the multiplicand when mq[0] is set.
    assign w_add   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    // Divide: {acc, mq} shifts left, subtracting the divisor when it fits.
    assign w_shift = {r_acc, r_mq[XLEN-1]};
    assign w_sub   = w_shift - {1'b0, r_opb};
    assign w_qbit  = ~w_sub[XLEN];

    always_comb begin
        w_acc_nxt = r_acc;
        w_mq_nxt  = r_mq;
        if (w_is_div) begin
            w_acc_nxt = w_qbit ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
            w_mq_nxt  = {r_mq[XLEN-2:0], w_qbit};
        end else begin
            w_acc_nxt = w_add[XLEN:1];
            w_mq_nxt  = {w_add[0], r_mq[XLEN-1:1]};
        end
    end

    always_comb begin
        w_prod   = {r_acc, r_mq};
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        if (w_is_div) begin
            if (r_dvz) begin
                w_res_hi = r_rs;
                w_res_lo = {XLEN{1'b1}};
            end else begin
                w_res_hi = r_neg_r ? -r_acc : r_acc;
                w_res_lo = r_neg_q ? -r_mq  : r_mq;
            end
        end else begin
            if (r_neg_q) begin
                w_prod = -w_prod;
            end
            w_res_hi = w_prod[2*XLEN-1:XLEN];
            w_res_lo = w_prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= MD_MULT;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_opb   <= '0;
            r_rs    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dvz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (EX_md_start) begin
                        if (md_is_arith(EX_md_op)) begin
                            r_op    <= EX_md_op;
                            r_cnt   <= c_iters;
                            r_acc   <= '0;
                            r_rs    <= EX_rd1;
                            r_neg_q <= w_signed && (EX_rd1[XLEN-1] ^ EX_rd2[XLEN-1]);
                            r_neg_r <= (EX_md_op == MD_DIV) && EX_rd1[XLEN-1];
                            r_dvz   <= (EX_rd2 == '0);
                            r_state <= ST_RUN;
                            if (EX_md_op[1]) begin
                                r_mq  <= w_mag_a;
                                r_opb <= w_mag_b;
                            end else begin
                                r_mq  <= w_mag_b;
                                r_opb <= w_mag_a;
                            end
                        end else if (EX_md_op == MD_MTHI) begin
                            r_hi <= EX_rd1;
                        end else if (EX_md_op == MD_MTLO) begin
                            r_lo <= EX_rd1;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_mq  <= w_mq_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign MD_stall = (r_state != ST_IDLE);
    assign MD_done  = r_done;
    assign MD_hi    = r_hi;
    assign MD_lo    = r_lo;

endmodule
`default_nettype wire
